// File: rtl/out_port_tx_pkg.sv
// Shared definitions for out_port_tx: FSM state encodings, serial line levels and frame constants.
// Defining OUT_PORT_TX_PARITY_EN adds the PARITY state to the encoding.
package out_port_tx_pkg;

    localparam int   BITS_PER_BYTE        = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef OUT_PORT_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/out_port_tx_fifo.sv
// tx_fifo: synchronous word FIFO between the processor output strobe and the serialiser.
// A push while full is accepted only when a pop happens on the same edge.
module tx_fifo #(
    parameter int DataWidth = 16,
    parameter int FifoDepth = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] din,
    output logic [DataWidth-1:0] head,
    output logic                 full,
    output logic                 empty
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam logic [CntW-1:0] DepthCount = CntW'(FifoDepth);

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == DepthCount);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because the depth is a power of two; count saturates by construction.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_tx.sv
// out_port_tx: buffers OUT-instruction words and sends them on TXD, low byte first, LSB first.
// Build with OUT_PORT_TX_PARITY_EN for an even-parity bit between the data bits and STOP.
module out_port_tx
    import out_port_tx_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int ClksPerBit = DEFAULT_CLKS_PER_BIT,
    parameter int FifoDepth  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DataWidth-1:0] DATA,
    input  logic                 LOAD,
    output logic                 TXD,
    output logic                 BUSY,
    output logic                 FULL,
    output logic                 OVERRUN
);

    localparam int BytesPerWord = DataWidth / BITS_PER_BYTE;
    localparam int BaudW        = $clog2(ClksPerBit);
    localparam int ByteW        = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    localparam logic [2:0]       BitLast  = 3'(BITS_PER_BYTE - 1);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(BytesPerWord - 1);

    tx_state_t            state;
    logic [BaudW-1:0]     baud_cnt;
    logic [2:0]           bit_cnt;
    logic [ByteW-1:0]     byte_cnt;
    logic [DataWidth-1:0] shift_reg;
    logic [DataWidth-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 baud_done;
    logic                 last_byte;
    logic                 pop;
`ifdef OUT_PORT_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign baud_done = (baud_cnt == BaudLast);
    assign last_byte = (byte_cnt == ByteLast);
    // Popping at the end of the last STOP lets the next word start with no idle cycle.
    assign pop  = !fifo_empty &&
                  ((state == ST_IDLE) || ((state == ST_STOP) && baud_done && last_byte));
    assign FULL = fifo_full;

    tx_fifo #(
        .DataWidth(DataWidth),
        .FifoDepth(FifoDepth)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (LOAD),
        .pop   (pop),
        .din   (DATA),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            OVERRUN <= 1'b0;
        else if (LOAD && fifo_full && !pop)
            OVERRUN <= 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            TXD       <= STOP_BIT;
            BUSY      <= 1'b0;
`ifdef OUT_PORT_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            shift_reg <= fifo_head;
            byte_cnt  <= '0;
            baud_cnt  <= '0;
            state     <= ST_START;
            TXD       <= START_BIT;
            BUSY      <= 1'b1;
`ifdef OUT_PORT_TX_PARITY_EN
            parity_bit <= ^fifo_head[BITS_PER_BYTE-1:0];
`endif
        end else if (state != ST_IDLE) begin
            if (!baud_done) begin
                baud_cnt <= baud_cnt + BaudW'(1);
            end else begin
                baud_cnt <= '0;
                // The shift register is consumed one bit per data slot, so after a byte its low
                // eight bits already hold the next byte of the word.
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        TXD     <= shift_reg[0];
                    end
                    ST_DATA: begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BitLast) begin
`ifdef OUT_PORT_TX_PARITY_EN
                            state <= ST_PARITY;
                            TXD   <= parity_bit;
`else
                            state <= ST_STOP;
                            TXD   <= STOP_BIT;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            TXD     <= shift_reg[1];
                        end
                    end
`ifdef OUT_PORT_TX_PARITY_EN
                    ST_PARITY: begin
                        state <= ST_STOP;
                        TXD   <= STOP_BIT;
                    end
`endif
                    ST_STOP: begin
                        if (!last_byte) begin
                            byte_cnt <= byte_cnt + ByteW'(1);
                            state    <= ST_START;
                            TXD      <= START_BIT;
`ifdef OUT_PORT_TX_PARITY_EN
                            parity_bit <= ^shift_reg[BITS_PER_BYTE-1:0];
`endif
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_out_port_tx.sv
// Directed self-checking bench for out_port_tx with ClksPerBit=4, FifoDepth=4, 16-bit words.
// Defining OUT_PORT_TX_PARITY_EN switches the expected frames to 11 bits and adds the parity vector.
module tb_out_port_tx;

    localparam int CPB = 4;
    localparam int DW  = 16;
`ifdef OUT_PORT_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CLKS = 2 * FRAME_BITS * CPB;

    logic          CLK;
    logic          RESET;
    logic          LOAD;
    logic [DW-1:0] DATA;
    logic          TXD;
    logic          BUSY;
    logic          FULL;
    logic          OVERRUN;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] words [6];
    logic [0:2*FRAME_BITS-1] streamA55A;
`ifdef OUT_PORT_TX_PARITY_EN
    logic [0:2*FRAME_BITS-1] stream0007;
`endif

    out_port_tx #(
        .DataWidth  (DW),
        .ClksPerBit (CPB),
        .FifoDepth  (4)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .DATA    (DATA),
        .LOAD    (LOAD),
        .TXD     (TXD),
        .BUSY    (BUSY),
        .FULL    (FULL),
        .OVERRUN (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected TXD level c clocks after the pop edge of a word: start, LSB-first data, [parity], stop.
    function automatic logic expTxd(input logic [DW-1:0] w, input int c);
        int bitIdx;
        int byteIdx;
        int pos;
        logic [7:0] b;
        bitIdx  = c / CPB;
        byteIdx = bitIdx / FRAME_BITS;
        pos     = bitIdx % FRAME_BITS;
        b       = w[byteIdx*8 +: 8];
        if (pos == 0)
            return 1'b0;
        if (pos <= 8)
            return b[pos-1];
`ifdef OUT_PORT_TX_PARITY_EN
        if (pos == 9)
            return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents words[0..n-1] on consecutive clocks; returns at the falling edge after the last push.
    task automatic applyStimulus(input int n);
        LOAD = 1'b1;
        for (int i = 0; i < n; i++) begin
            DATA = words[i];
            @(posedge CLK);
            @(negedge CLK);
        end
        LOAD = 1'b0;
    endtask

    initial begin
        RESET = 1'b0;
        LOAD  = 1'b0;
        DATA  = '0;
`ifdef OUT_PORT_TX_PARITY_EN
        streamA55A = 22'b0_01011010_0_1_0_10100101_0_1;
        stream0007 = 22'b0_11100000_1_1_0_00000000_0_1;
`else
        streamA55A = 20'b0_01011010_1_0_10100101_1;
`endif

        // Test 1: reset values and quiet line after release.
        repeat (3) @(negedge CLK);
        checkOutput("reset_state", 32'({TXD, BUSY, FULL, OVERRUN}), 32'b1000);
        RESET = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            checkOutput("idle_after_reset", 32'({TXD, BUSY, FULL, OVERRUN}), 32'b1000);
        end

        // Test 2: single word 16'hA55A against the hand-written bit stream.
        words[0] = 16'hA55A;
        applyStimulus(1);
        checkOutput("a55a_before_pop", 32'({TXD, BUSY}), 32'b10);
        @(negedge CLK);
        for (int c = 0; c < WORD_CLKS; c++) begin
            checkOutput("a55a_txd", 32'(TXD), 32'(streamA55A[c / CPB]));
            checkOutput("a55a_busy", 32'(BUSY), 32'd1);
            @(negedge CLK);
        end
        checkOutput("a55a_busy_fall", 32'({TXD, BUSY}), 32'b10);

        // Test 3: six back-to-back loads; the sixth is dropped and words 1-5 stream out.
        words[0] = 16'h1357;
        words[1] = 16'h2468;
        words[2] = 16'h9ABC;
        words[3] = 16'hDEF0;
        words[4] = 16'h0FF0;
        words[5] = 16'h5555;
        applyStimulus(6);
        checkOutput("burst_full", 32'(FULL), 32'd1);
        checkOutput("burst_overrun", 32'(OVERRUN), 32'd1);
        for (int c = 4; c < 5 * WORD_CLKS; c++) begin
            checkOutput("burst_txd", 32'(TXD), 32'(expTxd(words[c / WORD_CLKS], c % WORD_CLKS)));
            checkOutput("burst_busy", 32'(BUSY), 32'd1);
            if (c == WORD_CLKS)
                checkOutput("burst_full_after_pop", 32'(FULL), 32'd0);
            @(negedge CLK);
        end
        checkOutput("burst_end", 32'({TXD, BUSY, FULL, OVERRUN}), 32'b1001);

        // Test 4: load on the same edge as the pop of word 2 is accepted while full.
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("overrun_cleared", 32'(OVERRUN), 32'd0);
        applyStimulus(5);
        checkOutput("fill_full", 32'({FULL, OVERRUN}), 32'b10);
        for (int c = 3; c < 6 * WORD_CLKS; c++) begin
            checkOutput("fill_txd", 32'(TXD), 32'(expTxd(words[c / WORD_CLKS], c % WORD_CLKS)));
            if (c == WORD_CLKS - 1) begin
                checkOutput("fill_full_pre_pop", 32'(FULL), 32'd1);
                LOAD = 1'b1;
                DATA = words[5];
            end
            if (c == WORD_CLKS) begin
                LOAD = 1'b0;
                checkOutput("pop_push_full", 32'(FULL), 32'd1);
                checkOutput("pop_push_overrun", 32'(OVERRUN), 32'd0);
            end
            @(negedge CLK);
        end
        checkOutput("fill_end", 32'({TXD, BUSY, FULL, OVERRUN}), 32'b1000);

        // Test 5: asynchronous reset during data bit 3 of byte 0 aborts the frame and the queue.
        words[0] = 16'h1234;
        words[1] = 16'hFFFF;
        words[2] = 16'h00FF;
        applyStimulus(3);
        repeat (16) @(negedge CLK);
        checkOutput("abort_bit3_level", 32'({TXD, BUSY, FULL}), 32'b010);
        #1 RESET = 1'b0;
        #1 checkOutput("abort_async", 32'({TXD, BUSY, FULL, OVERRUN}), 32'b1000);
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            checkOutput("abort_queue_gone", 32'({TXD, BUSY}), 32'b10);
        end
        words[0] = 16'hC3E1;
        applyStimulus(1);
        @(negedge CLK);
        for (int c = 0; c < WORD_CLKS; c++) begin
            checkOutput("after_abort_txd", 32'(TXD), 32'(expTxd(words[0], c)));
            checkOutput("after_abort_busy", 32'(BUSY), 32'd1);
            @(negedge CLK);
        end
        checkOutput("after_abort_end", 32'({TXD, BUSY}), 32'b10);

`ifdef OUT_PORT_TX_PARITY_EN
        // Test 6: even parity, 16'h0007 gives parity 1 on byte 0 and 0 on byte 1.
        words[0] = 16'h0007;
        applyStimulus(1);
        @(negedge CLK);
        for (int c = 0; c < WORD_CLKS; c++) begin
            checkOutput("parity_txd", 32'(TXD), 32'(stream0007[c / CPB]));
            checkOutput("parity_busy", 32'(BUSY), 32'd1);
            @(negedge CLK);
        end
        checkOutput("parity_end", 32'({TXD, BUSY}), 32'b10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
